// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcodes, default latencies, FSM states.
package e_mdu_pkg;

  localparam logic [3:0] mdu_none  = 4'd0;
  localparam logic [3:0] mdu_mult  = 4'd1;
  localparam logic [3:0] mdu_multu = 4'd2;
  localparam logic [3:0] mdu_div   = 4'd3;
  localparam logic [3:0] mdu_divu  = 4'd4;
  localparam logic [3:0] mdu_mfhi  = 4'd5;
  localparam logic [3:0] mdu_mflo  = 4'd6;
  localparam logic [3:0] mdu_mthi  = 4'd7;
  localparam logic [3:0] mdu_mtlo  = 4'd8;

  localparam int mdu_mult_cycles_def = 5;
  localparam int mdu_div_cycles_def  = 10;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_mul  = 2'd1,
    st_div  = 2'd2
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == mdu_mult) || (op == mdu_multu);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == mdu_div) || (op == mdu_divu);
  endfunction

endpackage

// File: rtl/e_mdu_core.sv
// Combinational datapath of the MDU: 64-bit {hi,lo} result and divide-by-zero flag.
module e_mdu_core
  import e_mdu_pkg::*;
(
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] res,
  output logic        dz
);

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, bm_safe;
  logic [31:0] q_s, r_s, q_u, r_u;

  always_comb begin
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    a_sx   = {{32{A[31]}}, A};
    b_sx   = {{32{B[31]}}, B};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, A} * {32'd0, B};
    // Signed divide on magnitudes; this also yields 0x80000000 / -1 = 0x80000000 without overflow.
    a_mag   = A[31] ? (~A + 32'd1) : A;
    b_mag   = B[31] ? (~B + 32'd1) : B;
    b_safe  = (B == 32'd0) ? 32'd1 : B;
    bm_safe = (B == 32'd0) ? 32'd1 : b_mag;
    q_s = a_mag / bm_safe;
    r_s = a_mag % bm_safe;
    q_u = A / b_safe;
    r_u = A % b_safe;
    res = 64'd0;
    dz  = 1'b0;
    case (MDUOp)
      mdu_mult:  res = prod_s;
      mdu_multu: res = prod_u;
      mdu_div: begin
        res[31:0]  = (A[31] ^ B[31]) ? (~q_s + 32'd1) : q_s;
        res[63:32] = A[31] ? (~r_s + 32'd1) : r_s;
        dz         = (B == 32'd0);
      end
      mdu_divu: begin
        res = {r_u, q_u};
        dz  = (B == 32'd0);
      end
      default: res = 64'd0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: sequencing FSM, pending result and architectural HI/LO.
// Optional MDU_CANCEL_EN adds a `cancel` input that aborts or suppresses MDU activity.
//
// Handshake: start is a one-cycle launch pulse accepted only when busy==0 and MDUOp is an
// arithmetic op; busy is high from the cycle after launch until the cycle HI/LO update.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = mdu_mult_cycles_def,
  parameter int DIV_CYCLES  = mdu_div_cycles_def
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] result,
  output logic [1:0]  dbg_state
);

  mdu_state_e  state;
  logic [31:0] count;
  logic [31:0] hi, lo, pending_hi, pending_lo;
  logic        pending_dz;
  logic [63:0] core_res;
  logic        core_dz;
  logic        cancel_w;

`ifdef MDU_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  e_mdu_core u_core (
    .MDUOp (MDUOp),
    .A     (A),
    .B     (B),
    .res   (core_res),
    .dz    (core_dz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= st_idle;
      count      <= 32'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_dz <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        st_idle: begin
          if (!cancel_w) begin
            if (start && is_mul_op(MDUOp)) begin
              state      <= st_mul;
              count      <= 32'(MULT_CYCLES - 1);
              busy       <= 1'b1;
              pending_hi <= core_res[63:32];
              pending_lo <= core_res[31:0];
              pending_dz <= 1'b0;
            end else if (start && is_div_op(MDUOp)) begin
              state      <= st_div;
              count      <= 32'(DIV_CYCLES - 1);
              busy       <= 1'b1;
              pending_hi <= core_res[63:32];
              pending_lo <= core_res[31:0];
              pending_dz <= core_dz;
            end else if (MDUOp == mdu_mthi) begin
              hi <= A;
            end else if (MDUOp == mdu_mtlo) begin
              lo <= A;
            end
          end
        end
        st_mul, st_div: begin
          if (cancel_w) begin
            state <= st_idle;
            busy  <= 1'b0;
          end else if (count == 32'd0) begin
            // A divide by zero still spends its full latency but leaves HI/LO alone.
            if (!pending_dz) begin
              hi <= pending_hi;
              lo <= pending_lo;
            end
            state <= st_idle;
            busy  <= 1'b0;
          end else begin
            count <= count - 32'd1;
          end
        end
        default: begin
          state <= st_idle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    result = 32'd0;
    if (MDUOp == mdu_mfhi)      result = hi;
    else if (MDUOp == mdu_mflo) result = lo;
  end

  assign dbg_state = state;

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Multiply/divide unit in the E stage, alongside the ALU and fed by the same forwarded A/B operands.
- Executes mult/multu/div/divu as multi-cycle operations and owns the architectural HI/LO registers.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Drives `busy` to the hazard unit, which stalls D-stage MDU instructions while `start || busy`.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle pulse: launch MDUOp (mult/multu/div/divu only).
- MDUOp  input  4  operation code (mdu_* constants).
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- busy  output  1  operation in flight.
- result  output  32  HI for mdu_mfhi, LO for mdu_mflo, else 0; combinational.

Behaviour:
- Reset (async): state=IDLE, count=0, HI=0, LO=0, pending=0, busy=0.
- FSM states IDLE, MUL, DIV.
  - IDLE + start + MDUOp in {mult,multu}: go to MUL; count=MULT_CYCLES-1.
  - IDLE + start + MDUOp in {div,divu}: go to DIV; count=DIV_CYCLES-1.
  - At launch, the 64-bit result is computed from A/B and captured into pending{hi,lo}.
  - MUL/DIV with count!=0: count decrements each cycle.
  - MUL/DIV with count==0: write pending into HI/LO on that edge, then return to IDLE.
- busy is a registered output = (state != IDLE).
  - busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles, starting the cycle after start.
  - New HI/LO values are visible on `result` in the first cycle after busy falls.
- start while busy is ignored. Any MDUOp other than the four arithmetic ops, or mdu_none, is ignored on start.
- mthi/mtlo: when MDUOp==mdu_mthi/mdu_mtlo and busy==0, HI/LO takes A on the clock edge. No start is required. The write is ignored while busy.
- mfhi/mflo while busy return the old HI/LO. Preventing this is the hazard unit's job; e_mdu does not stall.
- Arithmetic:
  - mult: signed 32x32→64, {HI,LO}=product.
  - multu: unsigned 32x32→64, {HI,LO}=product.
  - div: LO=quotient truncated toward zero; HI=remainder, same sign as dividend.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned LO=quotient, HI=remainder.
  - Divide by zero (div or divu): full DIV_CYCLES busy period, but HI/LO are NOT updated at completion.
- Reset asserted mid-operation aborts it: no HI/LO write, busy=0 immediately (asynchronous).

Optional Feature:
- Macro MDU_CANCEL_EN.
- Defined: adds input port `cancel` (1 bit, driven by the exception/flush logic).
  - cancel high in MUL/DIV: go to IDLE on the next edge; pending is discarded; HI/LO unchanged; busy=0 the following cycle.
  - cancel high together with start: the launch is suppressed.
  - cancel high together with mthi/mtlo: the write is suppressed.
  - cancel high in the same cycle as completion (count==0): the write is suppressed.
- Undefined: the `cancel` port does not exist; every operation that starts runs to completion.

Decomposition:
- Shared header: mdu_none, mdu_mult, mdu_multu, mdu_div, mdu_divu, mdu_mfhi, mdu_mflo, mdu_mthi, mdu_mtlo as 4-bit `define constants, kept beside the alu_* codes.
- Cycle-count defaults also go in the header.
- One natural sub-module: e_mdu_core, purely combinational. It computes the 64-bit result and a div-by-zero flag from A, B and MDUOp. e_mdu keeps the FSM, counter, pending registers and HI/LO.

Test Plan:
- mult A=0xFFFFFFFF, B=2 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 → busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1.
- mthi 0x1234 then mtlo 0x5678 → divu A=5, B=0 → busy high 10 cycles; mfhi=0x1234, mflo=0x5678 afterwards. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- mult running, then in cycle 2 of busy: start with div, and separately mthi 0xDEAD → both ignored; HI/LO equal the mult result only.
- Reset asserted in busy cycle 3 of a div → busy=0 and HI=LO=0 without waiting for a clock edge. With MDU_CANCEL_EN, cancel in busy cycle 3 → busy=0 the next cycle; prior HI/LO preserved.
